// File: rtl/memory_access_arbiter.sv
// N-port memory access arbiter: zero-latency grant to one port, read-tag FIFO routing returns back to requesters.
// Optional port-0 exclusive lock is compiled in with `define RSD_MEM_ARBITER_LOCK_EN.
module memory_access_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 128,
  parameter int MAX_OUTSTANDING = 4,
  parameter int RR_MODE         = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_x,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] portAddr,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] portWriteData,
  input  logic [NUM_PORTS-1:0]                 portRE,
  input  logic [NUM_PORTS-1:0]                 portWE,
  input  logic                                 portLock,
  output logic [NUM_PORTS-1:0]                 portBusy,
  output logic [DATA_WIDTH-1:0]                portReadData,
  output logic [NUM_PORTS-1:0]                 portReadDataReady,
  output logic [ADDR_WIDTH-1:0]                memAccessAddr,
  output logic [DATA_WIDTH-1:0]                memAccessWriteData,
  output logic                                 memAccessRE,
  output logic                                 memAccessWE,
  input  logic                                 memAccessBusy,
  input  logic [DATA_WIDTH-1:0]                memReadData,
  input  logic                                 memReadDataReady,
  output logic                                 orphanReadError
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
  localparam int CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic              valid;
    logic [PORT_W-1:0] idx;
  } grant_t;

  // First requester strictly after 'last', wrapping modulo NUM_PORTS.
  function automatic grant_t pick_rr(input logic [NUM_PORTS-1:0] req,
                                     input logic [PORT_W-1:0]    last);
    grant_t g;
    int     cand;
    g = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      cand = (int'(last) + k) % NUM_PORTS;
      if (!g.valid && req[PORT_W'(cand)]) begin
        g.valid = 1'b1;
        g.idx   = PORT_W'(cand);
      end
    end
    return g;
  endfunction

  function automatic grant_t pick_fixed(input logic [NUM_PORTS-1:0] req);
    grant_t g;
    g = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[PORT_W'(i)]) begin
        g.valid = 1'b1;
        g.idx   = PORT_W'(i);
      end
    end
    return g;
  endfunction

  logic [PORT_W-1:0]    r_last_grant;
  logic                 r_hold_valid;
  logic [PORT_W-1:0]    r_hold_idx;
  logic [PORT_W-1:0]    r_tag_mem [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_orphan;

  logic [NUM_PORTS-1:0] w_req;
  logic [NUM_PORTS-1:0] w_req_elig;
  grant_t               w_grant;
  logic                 w_grant_is_read;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_read_blocked;
  logic                 w_accept;
  logic                 w_push;
  logic [PORT_W-1:0]    w_head;

  assign w_req = portRE | portWE;

`ifdef RSD_MEM_ARBITER_LOCK_EN
  logic r_lock;

  assign w_req_elig = r_lock ? {{(NUM_PORTS-1){1'b0}}, w_req[0]} : w_req;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_lock <= 1'b0;
    end else if (portLock && w_accept && (w_grant.idx == '0)) begin
      r_lock <= 1'b1;
    end else if (!portLock && w_empty) begin
      r_lock <= 1'b0;
    end
  end
`else
  logic w_unused_lock;

  assign w_unused_lock = portLock;
  assign w_req_elig    = w_req;
`endif

  // A port stalled by memAccessBusy keeps the grant even if a higher-ranked port appears.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_grant = '0;
    if (r_hold_valid && w_req_elig[r_hold_idx]) begin
      w_grant.valid = 1'b1;
      w_grant.idx   = r_hold_idx;
    end else if (RR_MODE != 0) begin
      w_grant = pick_rr(w_req_elig, r_last_grant);
    end else begin
      w_grant = pick_fixed(w_req_elig);
    end
  end

  // Write wins over a simultaneous read; the read is simply dropped.
  assign w_grant_is_read = w_grant.valid && !portWE[w_grant.idx];
  assign w_empty         = (r_count == '0);
  assign w_full          = (r_count == CNT_W'(MAX_OUTSTANDING));
  assign w_pop           = memReadDataReady && !w_empty;
  assign w_read_blocked  = w_grant_is_read && w_full && !w_pop;
  assign w_accept        = w_grant.valid && !memAccessBusy && !w_read_blocked;
  assign w_push          = w_accept && w_grant_is_read;
  assign w_head          = r_tag_mem[r_rd_ptr];

  always_comb begin
    portBusy          = '1;
    portReadDataReady = '0;
    memAccessRE       = 1'b0;
    memAccessWE       = 1'b0;
    if (rst_x) begin
      if (w_accept) portBusy[w_grant.idx] = 1'b0;
      if (w_pop)    portReadDataReady[w_head] = 1'b1;
      memAccessWE = w_grant.valid && portWE[w_grant.idx];
      memAccessRE = w_grant_is_read && !w_read_blocked;
    end
  end

  assign memAccessAddr      = portAddr[w_grant.idx];
  assign memAccessWriteData = portWriteData[w_grant.idx];
  assign portReadData       = memReadData;
  assign orphanReadError    = r_orphan;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_last_grant <= PORT_W'(NUM_PORTS - 1);
      r_hold_valid <= 1'b0;
      r_hold_idx   <= '0;
      r_orphan     <= 1'b0;
    end else begin
      if (w_accept) r_last_grant <= w_grant.idx;
      r_hold_valid <= w_grant.valid && memAccessBusy;
      r_hold_idx   <= w_grant.idx;
      if (memReadDataReady && w_empty) r_orphan <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: tag storage is deliberately not reset; r_count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) r_tag_mem[r_wr_ptr] <= w_grant.idx;
  end

endmodule

// File: doc/memory_access_arbiter.md
MEMORY_ACCESS_ARBITER -- requirements
Module: memory_access_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requesters, legal 2..8.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 128, memory entry width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 4, read-tag FIFO depth, power of two, 2..16.
REQ-005 SHALL have parameter RR_MODE, default 1: 1 = round-robin, 0 = fixed priority with lowest index winning.
REQ-006 SHALL have port clk, input, 1, the single clock.
REQ-007 SHALL have port rst_x, input, 1, reset; asynchronous, active-low.
REQ-008 SHALL have port portAddr, input, NUM_PORTS x ADDR_WIDTH, request address.
REQ-009 SHALL have port portWriteData, input, NUM_PORTS x DATA_WIDTH, write data.
REQ-010 SHALL have port portRE, input, NUM_PORTS, read request.
REQ-011 SHALL have port portWE, input, NUM_PORTS, write request.
REQ-012 SHALL have port portLock, input, 1, exclusive-access request from port 0.
REQ-013 SHALL have port portBusy, output, NUM_PORTS, request not accepted this cycle.
REQ-014 SHALL have port portReadData, output, DATA_WIDTH, read data broadcast to all ports.
REQ-015 SHALL have port portReadDataReady, output, NUM_PORTS, one-hot read return strobe.
REQ-016 SHALL have the following memory-side ports: memAccessAddr, output, ADDR_WIDTH; memAccessWriteData, output, DATA_WIDTH; memAccessRE, output, 1; memAccessWE, output, 1.
REQ-017 SHALL have the following memory-side ports: memAccessBusy, input, 1; memReadData, input, DATA_WIDTH; memReadDataReady, input, 1.
REQ-018 SHALL have port orphanReadError, output, 1, sticky flag for a read return with no outstanding tag.

Function
REQ-019 SHALL present one granted port's request to the memory combinationally in the same cycle, with zero added latency.
REQ-020 SHALL treat a port's request as accepted in a cycle when its request is asserted and portBusy[i]=0.
REQ-021 SHALL let WE win if a port asserts RE and WE together; the RE SHALL be dropped and SHALL NOT be queued.
REQ-022 SHALL, in fixed mode, grant the lowest-index requesting port.
REQ-023 SHALL, in RR mode, grant the first requesting port after lastGrant, in modulo NUM_PORTS order.
REQ-024 SHALL update lastGrant only on an accepted request.
REQ-025 SHALL hold the grant on the same port while memAccessBusy=1 and that port keeps requesting.
REQ-026 SHALL assert portBusy[i]=1 when any of the following holds: i is not granted; memAccessBusy=1; a read is requested while the tag FIFO is full.
REQ-027 SHALL push the granted port index into the tag FIFO on each accepted read.
REQ-028 SHALL, on memReadDataReady=1, pop the FIFO head and drive portReadDataReady[head]=1 in the same cycle, with portReadData equal to memReadData.
REQ-029 SHALL push and pop in the same cycle when both occur; occupancy SHALL then be unchanged. Push SHALL be blocked only by full-before-pop.
REQ-030 SHALL let FIFO read and write pointers wrap modulo MAX_OUTSTANDING.
REQ-031 SHALL track occupancy with log2(MAX_OUTSTANDING)+1 bits.
REQ-032 SHALL, on memReadDataReady=1 with an empty FIFO, drive no portReadDataReady and set orphanReadError=1 until reset.
REQ-033 SHALL keep memAccessRE=0 and memAccessWE=0 when no port is granted.

Reset
REQ-034 SHALL, while rst_x=0, reset the tag FIFO to empty.
REQ-035 SHALL, while rst_x=0, reset lastGrant to NUM_PORTS-1 so that port 0 is first.
REQ-036 SHALL, while rst_x=0, reset the lock state to 0 and orphanReadError to 0.
REQ-037 SHALL, while rst_x=0, drive memAccessRE=0 and memAccessWE=0, all portBusy=1 and portReadDataReady=0.
REQ-038 SHALL discard in-flight tags when reset is asserted mid-operation; later returns SHALL then count as orphans.

Configuration
REQ-039 SHALL, with macro RSD_MEM_ARBITER_LOCK_EN defined, latch a registered lock state when portLock=1 and port 0 has an accepted request.
REQ-040 SHALL, while the lock state is set, grant only port 0.
REQ-041 SHALL clear the lock state on the first cycle with portLock=0 and an empty tag FIFO.
REQ-042 SHALL, with RSD_MEM_ARBITER_LOCK_EN undefined, ignore portLock and remove all lock logic.

Verification
REQ-043 SHALL cover: NUM_PORTS=3, RR_MODE=1, all ports issue continuous reads, memory never busy -> grants 0,1,2,0,1,2 and returns routed in order.
REQ-044 SHALL cover: RR_MODE=0, ports 0 and 2 both request -> port 0 always granted; port 2 granted only once port 0 is idle.
REQ-045 SHALL cover: MAX_OUTSTANDING=4, five back-to-back reads with no returns -> fifth portBusy=1; on a return in the same cycle as the fifth read, the fifth is accepted and occupancy stays at 4.
REQ-046 SHALL cover: memAccessBusy held high 3 cycles under a port-1 request -> grant stays on port 1 and lastGrant is unchanged until acceptance.
REQ-047 SHALL cover: memReadDataReady with an empty FIFO -> no portReadDataReady and orphanReadError=1; rst_x pulsed low mid-stream -> FIFO empty and flag cleared.
REQ-048 SHALL cover, with RSD_MEM_ARBITER_LOCK_EN defined: portLock=1 with a port-0 write while port 1 requests -> port 1 busy until lock released and FIFO drained.
